// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Baud-rate constants, bit-time helper and scheduler state
//             encoding. uart_tx and uart_tx_sched both import this package,
//             so the two always agree on the bit time.
//  Contents : CLK_FREQ_DEF, BAUD_DEF, bit_cycles(), state_t
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 9600;

  // Clock cycles per bit. Integer division truncates, which matches the
  // way uart_tx counts out each bit.
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. The search starts one position
//             after the last winner and wraps modulo N_REQ. The pointer
//             register lives in the parent module.
//  Ports    : req    [N_REQ]  - pending requests
//             last   [ID_W]   - index of the previous winner
//             gnt    [N_REQ]  - one-hot winner; all zero when req is zero
//             gnt_id [ID_W]   - encoded winner index
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  logic w_found;
  int   w_idx;

  // The offsets run 1..N_REQ, so the last winner is checked last. This means
  // a requester that stays high is served again only after all the others.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(last) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_id     = ID_W'(w_idx);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched
//  Purpose  : Shares one uart_tx serializer among N_REQ byte producers.
//             A round-robin arbiter picks a request, the module latches the
//             byte and pulses tx_trig, and then no new trigger is issued for
//             one frame time plus a guard interval. This hold-off is needed
//             because uart_tx has no busy output.
//  Ports    : sclk, reset           - clock, sync active-high reset
//             req       [N_REQ]     - requests, held until acked
//             req_data  [N_REQ*8]   - byte i at [8i+7:8i]
//             grant_ack [N_REQ]     - one-cycle accept pulse
//             tx_data   [8]         - byte to uart_tx
//             tx_trig               - one-cycle start pulse to uart_tx
//             busy                  - from the trig cycle to the end of WAIT
//             cur_id    [log2 N]    - index of the last granted requester
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLK_FREQ     = CLK_FREQ_DEF,
  parameter int BAUD         = BAUD_DEF,
  parameter int FRAME_BITS   = 10,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                       sclk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*8-1:0]         req_data,
  output logic [N_REQ-1:0]           grant_ack,
  output logic [7:0]                 tx_data,
  output logic                       tx_trig,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   cur_id
);

  localparam int c_ID_W         = $clog2(N_REQ);
  localparam int c_BIT_CYCLES   = bit_cycles(CLK_FREQ, BAUD);
  localparam int c_FRAME_CYCLES = c_BIT_CYCLES * FRAME_BITS + GUARD_CYCLES;
  localparam int c_CNT_W        = $clog2(c_FRAME_CYCLES + 1);

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_ID_W-1:0]   r_last;
  logic [N_REQ-1:0]    w_gnt;
  logic [c_ID_W-1:0]   w_gnt_id;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (c_ID_W)
  ) u_arb (
    .req    (req),
    .last   (r_last),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= c_ID_W'(N_REQ - 1);
      tx_data   <= 8'h00;
      tx_trig   <= 1'b0;
      grant_ack <= '0;
      busy      <= 1'b0;
      cur_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          tx_trig   <= 1'b0;
          grant_ack <= '0;
          if (|req) begin
            tx_data   <= req_data[int'(w_gnt_id)*8 +: 8];
            cur_id    <= w_gnt_id;
            r_last    <= w_gnt_id;
            grant_ack <= w_gnt;
            tx_trig   <= 1'b1;
            busy      <= 1'b1;
            r_state   <= TRIG;
          end
        end
        TRIG: begin
          tx_trig   <= 1'b0;
          grant_ack <= '0;
          // The count runs FRAME_CYCLES-1 down to 0, so WAIT lasts
          // exactly FRAME_CYCLES cycles.
          r_cnt     <= c_CNT_W'(c_FRAME_CYCLES - 1);
          r_state   <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt - c_CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : uart_tx_sched
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` serializer between `N_REQ` byte producers. It arbitrates pending requests, latches the winning byte onto the serializer's `tx_data`, and fires a single-cycle `tx_trig`. `uart_tx` has no busy output, so the scheduler then blocks further triggers for one full frame time. It sits between the SoC's debug/console sources and the `uart_tx` instance driving `RS232_tx`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `CLK_FREQ`, 50_000_000: `sclk` frequency in Hz (20 ns period).
- `BAUD`, 9600: line rate; must match the `uart_tx` build.
- `FRAME_BITS`, 10: start bit + 8 data bits + 1 stop bit.
- `GUARD_CYCLES`, 16: extra idle cycles appended after each frame.

Ports:
- `sclk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, `N_REQ`: per-requester request. Held high until acked.
- `req_data`, in, `N_REQ*8`: byte i at bits [8i+7:8i]. Stable while `req[i]` is high.
- `grant_ack`, out, `N_REQ`: one-cycle pulse to the requester whose byte was accepted.
- `tx_data`, out, 8: to `uart_tx.tx_data`.
- `tx_trig`, out, 1: to `uart_tx.tx_trig`. Single-cycle pulse.
- `busy`, out, 1: high from the trig cycle through the end of WAIT.
- `cur_id`, out, `$clog2(N_REQ)`: index of the last granted requester.

## Operation
- Derived constants: `BIT_CYCLES = CLK_FREQ/BAUD`, integer-truncated (5208). `FRAME_CYCLES = BIT_CYCLES*FRAME_BITS + GUARD_CYCLES` (52096).
- Frame counter width is `$clog2(FRAME_CYCLES+1)` (16 bits at defaults). It is unsigned and never wraps.
- FSM states: IDLE, TRIG, WAIT.
- **IDLE**: if `|req` is high, the round-robin arbiter picks winner `w`.
  - Search starts at `last+1` modulo `N_REQ`.
  - Register `tx_data <= req_data[w]`, `cur_id <= w`, `last <= w`, `grant_ack[w] <= 1`.
  - Go to TRIG.
  - If no request is pending, stay in IDLE.
- **TRIG**: `tx_trig = 1` and `grant_ack[w] = 1` in this one cycle. Load counter with `FRAME_CYCLES-1`. Go to WAIT.
- **WAIT**: decrement the counter each cycle. When the counter equals 0, go to IDLE.
  - Requests are ignored during WAIT.
  - `tx_data` is held constant through WAIT.
- Round-robin pointer `last` resets to `N_REQ-1`, so requester 0 has first priority after reset.
- Simultaneous requests are served in rotating order. No requester waits more than `N_REQ` frames.
- A request deasserted before it is granted is simply dropped. No ack is produced for it.
- A requester that keeps `req` high after its ack is treated as a new request. It is served again only after the other pending requesters.
- Reset mid-frame: all state returns to reset values the next cycle. The serializer shares `reset` and is aborted with it.

## Timing
- Reset values: `tx_data` = 8'h00, `tx_trig` = 0, `grant_ack` = 0, `busy` = 0, `cur_id` = 0, state = IDLE, counter = 0, `last` = `N_REQ-1`.
- Request latency: `req` sampled high in IDLE at cycle N gives `tx_trig` and `grant_ack` at cycle N+1.
- The requester may change `req_data` or drop `req` from cycle N+2.
- Trig spacing: with continuous requests, consecutive `tx_trig` pulses are exactly `FRAME_CYCLES+2` cycles apart. At defaults this is 52098 cycles = 1,041,960 ns.
- `busy` rises at the TRIG cycle and falls at the first IDLE cycle.
- Exactly one `grant_ack` bit is high at a time. It is never high outside TRIG.
- `tx_trig` is never high for two consecutive cycles.

## Structure
- Shared package `uart_pkg` holds:
  - `CLK_FREQ` and `BAUD` defaults.
  - The `BIT_CYCLES` function.
  - The state enum `{IDLE, TRIG, WAIT}`.
- The package is also used by `uart_tx` so baud constants cannot diverge.
- One sub-module: `rr_arbiter`.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `gnt` and encoded `gnt_id`.
  - Purely combinational; the pointer register stays in `uart_tx_sched`.

## Test plan
- **Reset**: hold `reset=1` for 10 cycles with `req=4'b1111` -> all outputs at reset values, no `tx_trig`.
- **Single request**: `req[2]=1`, `req_data[2]=8'hC3` -> at the next cycle `tx_trig=1`, `tx_data=8'hC3`, `grant_ack=4'b0100`. `RS232_tx` shows the 0xC3 frame. `busy` stays high for 52097 cycles.
- **Contention**: `req=4'b1011` held continuously, bytes 0xA0/0xA1/–/0xA3 -> bytes sent in order 0xA0, 0xA1, 0xA3, 0xA0. Trigs are spaced 52098 cycles apart.
- **Request during WAIT**: `req[1]` rises 100 cycles after a trig -> no ack until WAIT ends. Ack arrives 1 cycle after the return to IDLE.
- **Withdrawn request**: `req[3]` pulses for 5 cycles during WAIT -> never acked, no extra trig.
- **Reset mid-frame**: assert `reset` 20000 cycles into WAIT -> next cycle is IDLE with `busy=0`. A pending `req[0]` is triggered 2 cycles after `reset` deasserts.
